// File: rtl/booth_seq_multiplier_if.sv
// Operand/product handshake bundle for booth_seq_multiplier.
//   in_valid/in_ready/in_m/in_q : operand pair accepted on in_valid & in_ready
//   out_valid/out_ready/product : signed 2*WIDTH-bit result handed downstream
//   busy                        : multiplier is iterating or holding a result
// master: the side that supplies operands and consumes products.
// slave : the multiplier itself.
interface booth_seq_multiplier_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_m;
  logic [WIDTH-1:0]     in_q;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid,
    output in_m,
    output in_q,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_m,
    input  in_q,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product,
    output busy
  );

endinterface

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier. One Booth step (add/sub of M followed
// by an arithmetic right shift of {A,Q,Q-1}) per clock, WIDTH steps per job.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (aborts any job in flight)
//   bus : slave side of booth_seq_multiplier_if
//         in_valid/in_ready/in_m/in_q  operand handshake (ready only in IDLE)
//         out_valid/out_ready/product  result handshake (valid only in DONE)
//         busy                         high in RUN and DONE
module booth_seq_multiplier #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  booth_seq_multiplier_if.slave bus
);

  // A carries one extra bit so the shift fill stays right when A +/- M
  // overflows WIDTH bits (e.g. M = -2^(WIDTH-1)).
  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [AW-1:0]     a;
  logic [AW-1:0]     a_nxt;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  q_nxt;
  logic              q_m1;
  logic              q_m1_nxt;
  logic [WIDTH-1:0]  m;
  logic [WIDTH-1:0]  m_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [PW-1:0]     product_q;
  logic [PW-1:0]     product_nxt;

  logic [AW-1:0]     m_ext;
  logic [AW-1:0]     s;
  logic [AW-1:0]     a_sh;
  logic [WIDTH-1:0]  q_sh;

  // One Booth step: recode {Q[0],Q-1}, then arithmetic shift of {S,Q}.
  always_comb begin
    m_ext = {m[WIDTH-1], m};
    s     = a;
    case ({q[0], q_m1})
      2'b10:   s = a - m_ext;
      2'b01:   s = a + m_ext;
      default: s = a;
    endcase
    a_sh = {s[AW-1], s[AW-1:1]};
    q_sh = {s[0], q[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_nxt   = state;
    a_nxt       = a;
    q_nxt       = q;
    q_m1_nxt    = q_m1;
    m_nxt       = m;
    count_nxt   = count;
    product_nxt = product_q;

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          m_nxt     = bus.in_m;
          q_nxt     = bus.in_q;
          a_nxt     = '0;
          q_m1_nxt  = 1'b0;
          count_nxt = '0;
          state_nxt = RUN;
        end
      end

      RUN: begin
        a_nxt     = a_sh;
        q_nxt     = q_sh;
        q_m1_nxt  = q[0];
        count_nxt = count + CNT_W'(1);
        // Final step still executes; its shifted result is the product.
        if (count == LAST_STEP) begin
          product_nxt = {a_sh[WIDTH-1:0], q_sh};
          state_nxt   = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a         <= '0;
      q         <= '0;
      q_m1      <= 1'b0;
      m         <= '0;
      count     <= '0;
      product_q <= '0;
    end else begin
      a         <= a_nxt;
      q         <= q_nxt;
      q_m1      <= q_m1_nxt;
      m         <= m_nxt;
      count     <= count_nxt;
      product_q <= product_nxt;
    end
  end

  // Handshake flags are pure decodes of the registered state.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.product   = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed bench for booth_seq_multiplier with hand-computed products.
module tb_booth_seq_multiplier;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;

  booth_seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

  booth_seq_multiplier #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Present operands and let the next rising edge accept them.
  task automatic start_job(input logic [31:0] m, input logic [31:0] q);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_m     = m;
    bus.in_q     = q;
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    check("release_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  logic [63:0] held;
  logic [31:0] b2b_m [3];
  logic [31:0] b2b_q [3];
  logic [63:0] b2b_p [3];

  initial begin
    int lat;
    int acc_cyc;
    int done_cyc;

    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_m      = '0;
    bus.in_q      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_product", bus.product, 64'd0);

    // 3 * 5 with exact latency
    start_job(32'd3, 32'd5);
    check("busy_in_run", 64'(bus.busy), 64'd1);
    wait_done(lat);
    check("lat_3x5", 64'(lat), 64'd32);
    check("prod_3x5", bus.product, 64'h0000_0000_0000_000F);
    release_result();

    // -7 * 6
    start_job(32'hFFFF_FFF9, 32'd6);
    wait_done(lat);
    check("prod_m7x6", bus.product, 64'hFFFF_FFFF_FFFF_FFD6);
    release_result();

    // Most-negative operands, overflow fill
    start_job(32'h8000_0000, 32'h8000_0000);
    wait_done(lat);
    check("prod_min_sq", bus.product, 64'h4000_0000_0000_0000);
    release_result();
    start_job(32'h7FFF_FFFF, 32'h8000_0000);
    wait_done(lat);
    check("prod_max_min", bus.product, 64'hC000_0000_8000_0000);
    release_result();

    // Back-pressure in DONE while new operands are offered
    start_job(32'd9, 32'hFFFF_FFFD);
    wait_done(lat);
    check("prod_9xm3", bus.product, 64'hFFFF_FFFF_FFFF_FFE5);
    held = bus.product;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_m     = 32'd100;
    bus.in_q     = 32'd2;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_product", bus.product, held);
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_m      = 32'd11;
    bus.in_q      = 32'd13;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("hold_release_idle", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("hold_reaccept_busy", 64'(bus.busy), 64'd1);
    wait_done(lat);
    check("lat_11x13", 64'(lat), 64'd32);
    check("prod_11x13", bus.product, 64'h0000_0000_0000_008F);
    release_result();

    // Reset during RUN aborts the job
    start_job(32'd5, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_product", bus.product, 64'd0);
    // Any stale pulse from the aborted job would cut this latency short.
    start_job(32'd0, 32'hFFFF_FFFF);
    wait_done(lat);
    check("lat_0xm1", 64'(lat), 64'd32);
    check("prod_0xm1", bus.product, 64'd0);
    release_result();

    // Back-to-back with in_valid and out_ready held high
    b2b_m[0] = 32'h1234_5678; b2b_q[0] = 32'hFFFF_FFFE; b2b_p[0] = 64'hFFFF_FFFF_DB97_5310;
    b2b_m[1] = 32'h7FFF_FFFF; b2b_q[1] = 32'h7FFF_FFFF; b2b_p[1] = 64'h3FFF_FFFF_0000_0001;
    b2b_m[2] = 32'hFFFF_FFFF; b2b_q[2] = 32'hFFFF_FFFF; b2b_p[2] = 64'h0000_0000_0000_0001;
    done_cyc = 0;
    @(negedge clk);
    bus.in_m      = b2b_m[0];
    bus.in_q      = b2b_q[0];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      check("b2b_accept", 64'(bus.busy), 64'd1);
      if (j > 0) check("b2b_spacing", 64'(acc_cyc - done_cyc), 64'd2);
      if (j < 2) begin
        bus.in_m = b2b_m[j+1];
        bus.in_q = b2b_q[j+1];
      end
      wait_done(lat);
      done_cyc = cyc;
      check("b2b_lat", 64'(lat), 64'd32);
      check("b2b_prod", bus.product, b2b_p[j]);
      @(posedge clk);
      #1;
      check("b2b_idle", 64'(bus.in_ready), 64'd1);
      if (j == 2) begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("final_idle_busy", 64'(bus.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
- Sequential radix-2 Booth multiplier controller. It wraps the per-iteration Booth step (add/subtract of M, then an arithmetic right shift of {A,Q,Q-1}) and runs it WIDTH times.
- Accepts a signed operand pair over a valid/ready handshake.
- Holds the iteration registers A, Q, Q-1, M and the iteration counter.
- Returns the signed 2*WIDTH-bit product over a valid/ready handshake to the downstream consumer.

Parameters:
- WIDTH, 32: operand width in bits. Product width is 2*WIDTH.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands (high only in IDLE).
- in_m  input  WIDTH  signed multiplicand M.
- in_q  input  WIDTH  signed multiplier Q.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts the product.
- product  output  2*WIDTH  signed product M*Q.
- busy  output  1  high in RUN and DONE.

Behaviour:
- States: IDLE, RUN, DONE. Registered state.
- Reset (rst=1 at a clock edge, highest priority in every state):
  - state=IDLE, A=0, Q=0, Q-1=0, M=0, count=0, product=0.
  - out_valid=0, busy=0, in_ready=1 from the next cycle.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded combinationally from the registered state.
- IDLE: on in_valid & in_ready:
  - load M=in_m, Q=in_q, A=0, Q-1=0, count=0.
  - go to RUN.
  - Otherwise hold.
- RUN, one Booth step per cycle, selected by pair {Q[0],Q-1}:
  - 00 or 11: S = A.
  - 10: S = A - M.
  - 01: S = A + M.
- Width rule for S:
  - A and S are WIDTH+1 bits, with M sign-extended by one bit.
  - This keeps the arithmetic-shift fill bit correct when the add/sub overflows WIDTH bits, including M = -2^(WIDTH-1).
- Shift: {A,Q,Q-1} <= {S[WIDTH], S, Q} >> 1. Equivalently:
  - A = {S[WIDTH], S[WIDTH:1]}
  - Q = {S[0], Q[WIDTH-1:1]}
  - Q-1 = Q[0] (old value).
- Counter: count increments each RUN cycle. On the cycle where count==WIDTH-1:
  - the step still executes,
  - product <= {shifted A[WIDTH-1:0], shifted Q},
  - state -> DONE.
- Latency: operands accepted at edge k give out_valid=1 after edge k+WIDTH. That is exactly WIDTH RUN cycles, independent of operand values (no early termination).
- DONE:
  - product and out_valid are held stable while out_ready=0.
  - On out_ready=1, the next state is IDLE and out_valid falls.
  - The product register keeps its last value until the next completion or reset.
- Throughput:
  - One result per WIDTH+2 cycles minimum: accept cycle, WIDTH RUN cycles, DONE for at least one cycle.
  - No new operand is accepted in DONE, even if out_ready and in_valid are high together.
- in_valid while busy: ignored. Operands are not latched and no error is raised.
- in_m and in_q changing during RUN: no effect, since M and Q are registered at accept.
- Reset mid-RUN or in DONE: the operation is aborted, no out_valid pulse, and the result is discarded.
- Signed wrap: A±M wraps modulo 2^(WIDTH+1). The final product is exact for all signed operand pairs, including (-2^(WIDTH-1))^2.

Test Plan:
- 3 * 5: out_valid exactly 32 cycles after accept; product=0x0000_0000_0000_000F.
- -7 (0xFFFFFFF9) * 6: product=0xFFFF_FFFF_FFFF_FFD6. Then out_ready=1 gives in_ready=1 on the next cycle.
- 0x80000000 * 0x80000000: product=0x4000_0000_0000_0000. 0x7FFFFFFF * 0x80000000: product=0xC000_0000_8000_0000 (overflow-fill check).
- out_ready held low 10 cycles in DONE, with in_valid=1 and new operands applied: product and out_valid stable, in_ready=0, new operands not captured. After release, the next accept uses the then-current inputs.
- rst=1 at RUN cycle 10: next cycle state IDLE, in_ready=1, out_valid=0, product=0, and out_valid never pulses for the aborted job. An immediate new job 0 * -1 then yields product=0.
- Back-to-back: in_valid and out_ready held high for 3 jobs (random signed pairs). Products match the 64-bit signed reference model, and each job's out_valid→next accept spacing is ≥1 cycle.
